// File: rtl/disto16x16_sched.sv
// disto16x16_sched: walks one shared, fully pipelined 4x4 distortion engine over the
// 16 sub-blocks of a 16x16 luma macroblock and sums the 16 engine results.
// One sub-block is issued per cycle, then the engine is drained and the total reported.
// An abort sends the block through a FLUSH phase that swallows results still in flight.
module disto16x16_sched #(
    parameter int DISTO_LAT = 3,
    parameter int SUM_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2047:0]     ina,
    input  logic [2047:0]     inb,
    input  logic [255:0]      w,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic              eng_start,
    output logic [127:0]      eng_ina,
    output logic [127:0]      eng_inb,
    output logic [255:0]      eng_w,
    input  logic [SUM_W-1:0]  eng_sum,
    input  logic              eng_done
);

    localparam int FW = $clog2(DISTO_LAT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        FLUSH = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2047:0]     lat_a;
    logic [2047:0]     lat_b;
    logic [255:0]      lat_w;
    logic [3:0]        blk;
    logic [4:0]        rcv;
    logic [4:0]        rcv_nxt;
    logic [SUM_W-1:0]  acc;
    logic [SUM_W-1:0]  acc_nxt;
    logic [SUM_W-1:0]  sum_q;
    logic [FW-1:0]     flush_cnt;
    logic              active;
    logic              accept;
    logic              last;

    // Decode the phase of the operation and the effect of this cycle's engine result.
    always_comb begin
        active  = (state == ISSUE) || (state == DRAIN);
        accept  = ((state == IDLE) || (state == DONE)) && start;
        acc_nxt = acc + eng_sum;
        rcv_nxt = rcv + 5'd1;
        last    = active && eng_done && (rcv_nxt == 5'd16);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs; abort takes priority over the final result.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        eng_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                eng_start = !abort;
                if (abort)             state_nxt = FLUSH;
                else if (last)         state_nxt = DONE;
                else if (blk == 4'd15) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort)     state_nxt = FLUSH;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? ISSUE : IDLE;
            end
            FLUSH: begin
                busy = 1'b1;
                if (flush_cnt == FW'(DISTO_LAT - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the macroblock on accept, step the issue index, and accumulate engine results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a     <= '0;
            lat_b     <= '0;
            lat_w     <= '0;
            blk       <= '0;
            rcv       <= '0;
            acc       <= '0;
            sum_q     <= '0;
            flush_cnt <= '0;
        end else begin
            if (accept) begin
                lat_a <= ina;
                lat_b <= inb;
                lat_w <= w;
                blk   <= '0;
                rcv   <= '0;
                acc   <= '0;
            end
            if ((state == ISSUE) && !abort) begin
                blk <= blk + 4'd1;
            end
            if (active && !abort && eng_done) begin
                acc <= acc_nxt;
                rcv <= rcv_nxt;
                if (rcv_nxt == 5'd16) sum_q <= acc_nxt;
            end
            if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
            else                flush_cnt <= '0;
        end
    end

    // Cut the current 4x4 sub-block out of the latched macroblocks (raster block order).
    always_comb begin
        eng_ina = '0;
        eng_inb = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                eng_ina[8*(4*i+j) +: 8] = lat_a[8*(16*(4*int'(blk[3:2]) + i) + 4*int'(blk[1:0]) + j) +: 8];
                eng_inb[8*(4*i+j) +: 8] = lat_b[8*(16*(4*int'(blk[3:2]) + i) + 4*int'(blk[1:0]) + j) +: 8];
            end
        end
    end

    assign eng_w = lat_w;
    assign sum   = sum_q;

endmodule

// File: tb/tb_disto16x16_sched.sv
// Testbench for disto16x16_sched with a behavioural engine model:
// eng_done is eng_start delayed DISTO_LAT cycles, eng_sum is issue index + 1
// (or a constant 0xFFFFFFF0 when big is set).
module tb_disto16x16_sched;

    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [2047:0] ina;
    logic [2047:0] inb;
    logic [255:0]  w;
    logic          busy;
    logic          done;
    logic [31:0]   sum;
    logic          eng_start;
    logic [127:0]  eng_ina;
    logic [127:0]  eng_inb;
    logic [255:0]  eng_w;
    logic [31:0]   eng_sum;
    logic          eng_done;

    logic                 clr = 1'b0;
    logic                 big = 1'b0;
    logic [4:0]           iss_cnt = '0;
    logic [LAT-1:0]       vpipe = '0;
    logic [LAT-1:0][4:0]  tpipe = '0;

    int tests_run = 0;
    int tests_failed = 0;

    disto16x16_sched #(.DISTO_LAT(LAT), .SUM_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .ina       (ina),
        .inb       (inb),
        .w         (w),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .eng_start (eng_start),
        .eng_ina   (eng_ina),
        .eng_inb   (eng_inb),
        .eng_w     (eng_w),
        .eng_sum   (eng_sum),
        .eng_done  (eng_done)
    );

    always #5 clk = ~clk;

    // Engine model: delay line of issue strobes tagged with the issue index.
    always @(posedge clk) begin
        vpipe <= {vpipe[LAT-2:0], eng_start};
        tpipe <= {tpipe[LAT-2:0], iss_cnt};
        if (clr)            iss_cnt <= '0;
        else if (eng_start) iss_cnt <= iss_cnt + 5'd1;
    end

    assign eng_done = vpipe[LAT-1];
    assign eng_sum  = big ? 32'hFFFF_FFF0 : (32'(tpipe[LAT-1]) + 32'd1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        ina = '0; inb = '0; w = '0;
        #3;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || eng_start !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl got busy=%0b done=%0b eng_start=%0b want 0 0 0", busy, done, eng_start);
        end
        tests_run++;
        if (sum !== 32'd0 || eng_w !== 256'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data got sum=%h want 0", sum);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit exp_es, exp_busy, exp_done;
        big = 1'b0;
        tick();
        start = 1'b1; clr = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_busy0 got %0b want 0", busy);
        end
        for (int c = 1; c <= 21; c++) begin
            tick();
            start = 1'b0; clr = 1'b0;
            #1;
            exp_es   = (c >= 1 && c <= 16);
            exp_busy = (c >= 1 && c <= 19);
            exp_done = (c == 20);
            tests_run++;
            if (eng_start !== exp_es || busy !== exp_busy || done !== exp_done) begin
                tests_failed++;
                $display("[TB] FAIL single_timing c=%0d got es=%0b busy=%0b done=%0b want %0b %0b %0b",
                         c, eng_start, busy, done, exp_es, exp_busy, exp_done);
            end
            if (c == 20) begin
                tests_run++;
                if (sum !== 32'd136) begin
                    tests_failed++;
                    $display("[TB] FAIL single_sum got %0d want 136", sum);
                end
            end
        end
    endtask

    task automatic test_slice();
        logic [127:0] exp_a;
        logic [127:0] exp_b;
        logic [255:0] exp_w;
        bit seen;
        for (int k = 0; k < 256; k++) begin
            ina[8*k +: 8] = 8'(k);
            inb[8*k +: 8] = 8'(255 - k);
        end
        for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'(16'h1234 + 16'(k * 257));
        exp_w = w;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp_a[8*(4*i+j) +: 8] = 8'(16*(4+i) + (4+j));
                exp_b[8*(4*i+j) +: 8] = 8'(255 - (16*(4+i) + (4+j)));
            end
        end
        tick();
        start = 1'b1; clr = 1'b1;
        tick();
        start = 1'b0; clr = 1'b0;
        ina = '0; inb = '0; w = '0;
        for (int c = 2; c <= 6; c++) tick();
        #1;
        tests_run++;
        if (eng_ina !== exp_a || eng_ina[7:0] !== 8'd68) begin
            tests_failed++;
            $display("[TB] FAIL slice_a blk5 got %h want %h", eng_ina, exp_a);
        end
        tests_run++;
        if (eng_inb !== exp_b) begin
            tests_failed++;
            $display("[TB] FAIL slice_b blk5 got %h want %h", eng_inb, exp_b);
        end
        tests_run++;
        if (eng_w !== exp_w) begin
            tests_failed++;
            $display("[TB] FAIL slice_w got %h want %h", eng_w, exp_w);
        end
        seen = 0;
        for (int c = 7; c <= 40 && !seen; c++) begin
            tick();
            #1;
            if (done === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen || sum !== 32'd136) begin
            tests_failed++;
            $display("[TB] FAIL slice_sum got done_seen=%0b sum=%0d want 1 136", seen, sum);
        end
    endtask

    task automatic test_start_held();
        int n_es;
        int done_cyc;
        n_es = 0;
        done_cyc = -1;
        tick();
        start = 1'b1; clr = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            clr = (c == 20);
            #1;
            if (c <= 20 && eng_start === 1'b1) n_es++;
            if (c == 20) begin
                tests_run++;
                if (done !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL held_done20 got %0b want 1", done);
                end
            end
            if (c == 21) begin
                tests_run++;
                if (busy !== 1'b1 || eng_start !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL held_reaccept got busy=%0b es=%0b want 1 1", busy, eng_start);
                end
            end
        end
        tests_run++;
        if (n_es != 16) begin
            tests_failed++;
            $display("[TB] FAIL held_issue_count got %0d want 16", n_es);
        end
        start = 1'b0; clr = 1'b0;
        for (int c = 22; c <= 50 && done_cyc < 0; c++) begin
            tick();
            #1;
            if (done === 1'b1) done_cyc = c;
        end
        tests_run++;
        if (done_cyc != 40 || sum !== 32'd136) begin
            tests_failed++;
            $display("[TB] FAIL held_second_op got done_cycle=%0d sum=%0d want 40 136", done_cyc, sum);
        end
    endtask

    task automatic test_wrap();
        int done_cyc;
        done_cyc = -1;
        big = 1'b1;
        tick();
        start = 1'b1; clr = 1'b1;
        for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
            tick();
            start = 1'b0; clr = 1'b0;
            #1;
            if (done === 1'b1) done_cyc = c;
        end
        tests_run++;
        if (done_cyc != 20 || sum !== 32'hFFFF_FF00) begin
            tests_failed++;
            $display("[TB] FAIL wrap_sum got done_cycle=%0d sum=%h want 20 ffffff00", done_cyc, sum);
        end
        tick();
        big = 1'b0;
    endtask

    task automatic test_abort();
        bit any_done;
        bit exp_busy;
        int done_cyc;
        any_done = 0;
        done_cyc = -1;
        tick();
        start = 1'b1; clr = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0; clr = 1'b0;
        end
        tick();
        abort = 1'b1;
        #1;
        tests_run++;
        if (eng_start !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_same_cycle got es=%0b busy=%0b want 0 1", eng_start, busy);
        end
        for (int c = 7; c <= 25; c++) begin
            tick();
            abort = 1'b0;
            #1;
            if (done === 1'b1) any_done = 1;
            exp_busy = (c <= 9);
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("[TB] FAIL abort_busy c=%0d got %0b want %0b", c, busy, exp_busy);
            end
        end
        tests_run++;
        if (any_done || sum !== 32'hFFFF_FF00) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_done got done_seen=%0b sum=%h want 0 ffffff00", any_done, sum);
        end
        tick();
        start = 1'b1; clr = 1'b1;
        for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
            tick();
            start = 1'b0; clr = 1'b0;
            #1;
            if (done === 1'b1) done_cyc = c;
        end
        tests_run++;
        if (done_cyc != 20 || sum !== 32'd136) begin
            tests_failed++;
            $display("[TB] FAIL abort_next_op got done_cycle=%0d sum=%0d want 20 136", done_cyc, sum);
        end
    endtask

    task automatic test_async_reset();
        bit bad;
        int done_cyc;
        bad = 0;
        done_cyc = -1;
        ina = {256{8'hA5}};
        w = {16{16'hBEEF}};
        tick();
        start = 1'b1; clr = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0; clr = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || eng_start !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL areset_ctrl got busy=%0b done=%0b es=%0b want 0 0 0", busy, done, eng_start);
        end
        tests_run++;
        if (sum !== 32'd0 || eng_ina !== 128'd0 || eng_w !== 256'd0) begin
            tests_failed++;
            $display("[TB] FAIL areset_data got sum=%0d ina=%h w=%h want 0", sum, eng_ina, eng_w);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            if (busy !== 1'b0 || done !== 1'b0) bad = 1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("[TB] FAIL areset_ignore_inflight got activity after reset want idle");
        end
        tick();
        start = 1'b1; clr = 1'b1;
        for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
            tick();
            start = 1'b0; clr = 1'b0;
            #1;
            if (done === 1'b1) done_cyc = c;
        end
        tests_run++;
        if (done_cyc != 20 || sum !== 32'd136) begin
            tests_failed++;
            $display("[TB] FAIL areset_next_op got done_cycle=%0d sum=%0d want 20 136", done_cyc, sum);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_slice();
        test_start_held();
        test_wrap();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
